pipe_reg: RTL and testbench
===========================

# pipe_reg

Parametrised elastic register pipeline for the SerDes datapath. Carries a WIDTH-bit word through DEPTH register stages under valid/ready flow control. Bubbles collapse, and backpressure stalls only the stages that are full. Provides asynchronous reset, synchronous flush and a configurable data-reset policy. It is the general replacement for hand-written single flops between datapath blocks.

## Interface
Parameters:
- WIDTH, 8: data word width, ≥1
- DEPTH, 3: number of register stages, ≥1
- RST_VAL, '0: WIDTH-bit value loaded into data registers on reset
- RESET_DATA, 1: 1 = data registers reset to RST_VAL; 0 = data registers are non-resettable (only valid bits reset)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all stage valid bits
- in_valid  in  1  upstream word present
- in_ready  out  1  pipeline accepts word this cycle
- in_data  in  WIDTH  upstream word
- out_valid  out  1  last stage holds a word
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  last-stage data
- count  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stage i holds v[i] and d[i]. Stage 0 is the input and stage DEPTH-1 is the output.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Advance terms: adv[DEPTH-1] = !v[DEPTH-1] | out_ready; adv[i] = !v[i] | adv[i+1].
- in_ready = adv[0] & !flush.
- Stage i loads from stage i-1 (stage 0 from in_data/in_valid) when adv[i]. Otherwise it holds both v and d.
- Data registers load only when the incoming valid is 1, so data does not toggle on bubbles. Valid bits load unconditionally on advance.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- count: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur. It always equals the popcount of v.
- flush: all v cleared at the next edge and count becomes 0. An output transfer in the flush cycle still completes. in_ready is 0, so the input is not accepted. Data registers are unaffected.
- rst (asynchronous) forces all v = 0 and count = 0 immediately. d = RST_VAL when RESET_DATA=1; d is unchanged when RESET_DATA=0.
- Reset values: out_valid 0, count 0, in_ready 1 once rst is released and flush is low, out_data RST_VAL (RESET_DATA=1).

## Timing
- Latency: DEPTH cycles from input transfer to out_valid when the pipeline is unstalled.
- Throughput: one word per cycle when out_ready is held high.
- The ready path is combinational from out_ready to in_ready, through DEPTH stages.
- Full pipeline (count=DEPTH) with out_ready=0: in_ready=0 and every stage holds.
- Full pipeline with out_ready=1: in_ready=1. Simultaneous in/out transfer keeps count=DEPTH.
- Partial stall: leading stages hold while an empty downstream slot fills (bubble collapse in a single cycle).
- Mid-operation reset: stored words are discarded. Operation resumes on the first edge after rst deasserts.
- Data ordering is strictly FIFO. There is no duplication or loss except via flush or rst.

## Structure
- Shared package pipe_pkg: count-width function cnt_w(depth) = $clog2(depth+1). Parameter-check constants live here.
- Sub-module pipe_stage (WIDTH, RST_VAL, RESET_DATA): one valid+data register with load enable. It is instantiated DEPTH times via generate.
- Top level owns the adv chain, the count register and the flush gating.
- Elaboration-time assertion: DEPTH ≥ 1 and WIDTH ≥ 1.

## Test plan
- Reset, RST_VAL=8'hA5, RESET_DATA=1, DEPTH=3: assert rst mid-cycle -> out_valid=0, count=0, out_data=8'hA5 without waiting for a clock edge.
- Streaming, out_ready=1, push 8'h01..8'h08 back-to-back -> out_data 8'h01 first valid 3 cycles after first push, then one word per cycle in order, count steady at 3.
- Backpressure: out_ready=0, push 4 words -> in_ready drops after 3 accepted, count=3. Raise out_ready -> the 4th word is accepted the same cycle and order is preserved.
- Bubble collapse: push 8'h11, idle 1 cycle, push 8'h22 with out_ready=0 -> both words pack into the last two stages, count=2.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> head word transfers, input is rejected, count=0 next cycle.
- RESET_DATA=0: load 8'h5A, assert rst -> out_valid=0, count=0, and d[DEPTH-1] still holds 8'h5A.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic register pipeline: count width helper
// and the parameter limits checked at elaboration.
package pipe_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MIN_DEPTH = 1;

    // Bits needed to represent 0..depth valid stages.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int width, input int depth);
        return (width >= MIN_WIDTH) && (depth >= MIN_DEPTH);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a data word, loaded when the slot advances.
// Data only captures real words so bubbles never toggle the data flops.
module pipe_stage #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               RESET_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic d_ld;

    assign d_ld = ld & vin & ~clr & ~rst;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      v <= 1'b0;
        else if (clr) v <= 1'b0;
        else if (ld)  v <= vin;
    end

    generate
        if (RESET_DATA) begin : g_rst_data
            always_ff @(posedge clk or posedge rst) begin
                if (rst)       d <= RST_VAL;
                else if (d_ld) d <= din;
            end
        end else begin : g_norst_data
            // NOTE: data flops without reset are deliberate; validity comes from v, so reset on d is optional.
            always_ff @(posedge clk) begin
                if (d_ld) d <= din;
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_reg.sv
// Elastic valid/ready register pipeline of DEPTH stages with bubble collapse,
// synchronous flush and a running count of occupied stages.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 3,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               RESET_DATA = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
        $fatal(1, "pipe_reg: WIDTH and DEPTH must both be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] vin;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [WIDTH-1:0] din [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage advances if it is empty or anything downstream of it advances,
    // i.e. out_ready or any empty slot at or beyond it.
    always_comb begin
        logic acc;
        // NOTE: always_comb assigns defaults first so no path leaves a variable unassigned (no latch).
        adv = '0;
        // NOTE: blocking assignment here because acc must carry its updated value to the next iteration.
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            adv[i] = acc;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign vin[i] = in_valid;
                assign din[i] = in_data;
            end else begin : g_body
                assign vin[i] = v[i-1];
                assign din[i] = d[i-1];
            end

            pipe_stage #(
                .WIDTH      (WIDTH),
                .RST_VAL    (RST_VAL),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .clr (flush),
                .ld  (adv[i]),
                .vin (vin[i]),
                .din (din[i]),
                .v   (v[i]),
                .d   (d[i])
            );
        end
    endgenerate

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        count <= '0;
        else if (flush)                 count <= '0;
        else if (in_xfer && !out_xfer)  count <= count + CW'(1);
        else if (out_xfer && !in_xfer)  count <= count - CW'(1);
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: directed vector table, streaming and reset sequences,
// and a randomized run against a slot-position reference model.
module tb_pipe_reg;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    logic          rst2, flush2, in_valid2, out_ready2;
    logic [W-1:0]  in_data2;
    logic          in_ready2, out_valid2;
    logic [W-1:0]  out_data2;
    logic [CW-1:0] count2;

    pipe_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'hA5), .RESET_DATA(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count)
    );

    pipe_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'h00), .RESET_DATA(1'b0)) dut_nr (
        .clk(clk), .rst(rst2), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .count(count2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: words in arrival order, each tagged with its slot index.
    logic [W-1:0] m_data[$];
    int           m_pos[$];

    task automatic model_step(input logic iv, input logic [W-1:0] id, input logic ordy,
                              input logic fl, output logic ir);
        if (m_data.size() > 0 && m_pos[0] == D - 1 && ordy) begin
            void'(m_data.pop_front());
            void'(m_pos.pop_front());
        end
        for (int k = 0; k < m_pos.size(); k++)
            if (m_pos[k] + 1 < D && (k == 0 || m_pos[k-1] != m_pos[k] + 1))
                m_pos[k] = m_pos[k] + 1;
        ir = !fl && (m_pos.size() == 0 || m_pos[m_pos.size()-1] != 0);
        if (fl) begin
            m_data.delete();
            m_pos.delete();
        end else if (iv && ir) begin
            m_data.push_back(id);
            m_pos.push_back(0);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic         e_ir;
        int           e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic exp_ir;
        logic exp_ov;
        logic [W-1:0] id;
        logic iv, ordy, fl;

        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2};
        tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2};
        tbl[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3};
        tbl[6]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 3};
        tbl[7]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 3};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};
        tbl[9]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        rst2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_data", 32'(out_data), 32'hA5);
        @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed bubble-collapse / backpressure / flush table.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov)
                check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
        end

        // Back-to-back streaming 01..08 with out_ready held high.
        for (int c = 0; c < 11; c++) begin
            drive(c < 8, 8'(c + 1), 1'b1, 1'b0);
            check($sformatf("stream%0d_in_ready", c), 32'(in_ready), 32'd1);
            check($sformatf("stream%0d_out_valid", c), 32'(out_valid), 32'(c >= 3));
            if (c >= 3)
                check($sformatf("stream%0d_out_data", c), 32'(out_data), 32'(c - 2));
            if (c >= 3 && c <= 7)
                check($sformatf("stream%0d_count", c), 32'(count), 32'd3);
        end

        // Asynchronous reset in the middle of a cycle discards the held word.
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_out_data", 32'(out_data), 32'h77);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'hA5);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        check("resume_in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("resume_count", 32'(count), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("resume_out_valid", 32'(out_valid), 32'd1);
        check("resume_out_data", 32'(out_data), 32'h99);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("resume_empty", 32'(count), 32'd0);

        // Randomized traffic against the reference model.
        m_data.delete();
        m_pos.delete();
        for (int c = 0; c < 400; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            id   = 8'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            drive(iv, id, ordy, fl);
            exp_ov = (m_data.size() > 0) && (m_pos[0] == D - 1);
            check($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(exp_ov));
            if (exp_ov)
                check($sformatf("rnd%0d_out_data", c), 32'(out_data), 32'(m_data[0]));
            check($sformatf("rnd%0d_count", c), 32'(count), 32'(m_data.size()));
            model_step(iv, id, ordy, fl, exp_ir);
            check($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(exp_ir));
        end

        // Non-resettable data variant keeps its word across reset.
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = 8'h5A; out_ready2 = 1'b0;
        @(negedge clk);
        in_valid2 = 1'b0; in_data2 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("nr_out_valid", 32'(out_valid2), 32'd1);
        check("nr_out_data", 32'(out_data2), 32'h5A);
        check("nr_count", 32'(count2), 32'd1);
        #2 rst2 = 1'b1;
        #1;
        check("nr_rst_out_valid", 32'(out_valid2), 32'd0);
        check("nr_rst_count", 32'(count2), 32'd0);
        check("nr_rst_out_data", 32'(out_data2), 32'h5A);
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        #1;
        check("nr_post_rst_out_data", 32'(out_data2), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
